// File: rtl/cache_pkg.sv
// Shared types and constants for the cache/memory arbiter: line geometry,
// owner encoding, arbiter FSM states and the line-alignment helper.
package cache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BEAT_W     = $clog2(LINE_WORDS);
    localparam int LINE_BYTES = LINE_WORDS * DATA_W / 8;

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

    typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WBEAT = 3'd2,
        ST_WRESP = 3'd3,
        ST_RBEAT = 3'd4,
        ST_DONE  = 3'd5
    } arb_state_e;

    // Clears the byte-within-line offset so bursts always start on a line boundary.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~OFF_MASK;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: combinational pick, registered memory
// of the last owner served, updated when a transaction completes.
module rr_arb2
    import cache_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_i,
    input  logic i_req_d,
    input  logic i_upd,
    input  logic i_upd_owner,
    output logic o_valid,
    output logic o_pick_d,
    output logic o_rr_last
);

    owner_e r_rr_last;

    // Reset value makes the dcache win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= OWN_I;
        end else if (i_upd) begin
            r_rr_last <= owner_e'(i_upd_owner);
        end
    end

    always_comb begin
        o_valid  = i_req_i | i_req_d;
        o_pick_d = 1'b0;
        if (i_req_i && i_req_d) begin
            o_pick_d = (r_rr_last == OWN_I);
        end else begin
            o_pick_d = i_req_d;
        end
    end

    assign o_rr_last = r_rr_last;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one beat-serial memory bus between icache refills and dcache
// refills/writebacks, moving whole lines and returning a one-cycle gnt.
module cache_mem_arbiter
    import cache_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_rd_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_gnt,
    input  logic                         d_rd_req,
    input  logic                         d_wr_req,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] d_wr_data,
    output logic                         d_gnt,
    output logic [LINE_WORDS*DATA_W-1:0] line_rdata,
    output logic                         m_avalid,
    input  logic                         m_aready,
    output logic                         m_we,
    output logic [ADDR_W-1:0]            m_addr,
    output logic                         m_wvalid,
    output logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_wready,
    input  logic                         m_bvalid,
    input  logic                         m_rvalid,
    input  logic [DATA_W-1:0]            m_rdata,
    output logic [2:0]                   o_dbg_state,
    output logic [BEAT_W-1:0]            o_dbg_beat_cnt,
    output logic                         o_dbg_rr_last
);

    // Bus handshakes: an address or write beat transfers on a clock edge where
    // valid and ready are both high; read beats and the write response are
    // single-cycle strobes that are always accepted in their own state.

    arb_state_e          r_state;
    arb_state_e          w_next;
    owner_e              r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    line_t               r_buf;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_dropped;

    logic                w_d_req;
    logic                w_arb_valid;
    logic                w_pick_d;
    logic                w_accept;
    logic                w_last_beat;
    logic                w_owner_req;
    logic                w_in_burst;
    logic                w_rr_upd;
    logic                w_rr_last;

    assign w_d_req     = d_rd_req | d_wr_req;
    assign w_accept    = (r_state == ST_IDLE) && w_arb_valid;
    assign w_last_beat = (r_beat_cnt == BEAT_W'(LINE_WORDS - 1));
    assign w_owner_req = (r_owner == OWN_D) ? w_d_req : i_rd_req;
    assign w_in_burst  = r_state inside {ST_ADDR, ST_WBEAT, ST_WRESP, ST_RBEAT};

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_i     (i_rd_req),
        .i_req_d     (w_d_req),
        .i_upd       (w_rr_upd),
        .i_upd_owner (r_owner),
        .o_valid     (w_arb_valid),
        .o_pick_d    (w_pick_d),
        .o_rr_last   (w_rr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        m_avalid = 1'b0;
        m_wvalid = 1'b0;
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        w_rr_upd = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_avalid = 1'b1;
                if (m_aready) begin
                    w_next = r_we ? ST_WBEAT : ST_RBEAT;
                end
            end
            ST_WBEAT: begin
                m_wvalid = 1'b1;
                if (m_wready && w_last_beat) begin
                    w_next = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (m_bvalid) begin
                    w_next = ST_DONE;
                end
            end
            ST_RBEAT: begin
                if (m_rvalid && w_last_beat) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A requester that let go mid-burst gets no completion.
                w_next   = ST_IDLE;
                w_rr_upd = 1'b1;
                i_gnt    = (r_owner == OWN_I) && !r_dropped;
                d_gnt    = (r_owner == OWN_D) && !r_dropped;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner    <= OWN_I;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_buf      <= '0;
            r_beat_cnt <= '0;
            r_dropped  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dropped <= 1'b0;
            end else if (w_in_burst && !w_owner_req) begin
                r_dropped <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_owner <= w_pick_d ? OWN_D : OWN_I;
                        r_we    <= w_pick_d & d_wr_req;
                        r_addr  <= line_align(w_pick_d ? d_addr : i_addr);
                        if (w_pick_d && d_wr_req) begin
                            r_buf <= d_wr_data;
                        end
                    end
                end
                ST_ADDR: begin
                    r_beat_cnt <= '0;
                end
                ST_WBEAT: begin
                    if (m_wready) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                ST_RBEAT: begin
                    if (m_rvalid) begin
                        r_buf[r_beat_cnt] <= m_rdata;
                        r_beat_cnt        <= r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_we           = m_avalid & r_we;
    assign m_addr         = r_addr;
    assign m_wdata        = m_wvalid ? r_buf[r_beat_cnt] : '0;
    assign line_rdata     = r_buf;
    assign o_dbg_state    = r_state;
    assign o_dbg_beat_cnt = r_beat_cnt;
    assign o_dbg_rr_last  = w_rr_last;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: drives both cache ports and a
// scripted bus, checking every observation with an immediate assertion.
module tb_cache_mem_arbiter;
    import cache_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         i_rd_req;
    logic [31:0]  i_addr;
    logic         i_gnt;
    logic         d_rd_req;
    logic         d_wr_req;
    logic [31:0]  d_addr;
    logic [255:0] d_wr_data;
    logic         d_gnt;
    logic [255:0] line_rdata;
    logic         m_avalid;
    logic         m_aready;
    logic         m_we;
    logic [31:0]  m_addr;
    logic         m_wvalid;
    logic [31:0]  m_wdata;
    logic         m_wready;
    logic         m_bvalid;
    logic         m_rvalid;
    logic [31:0]  m_rdata;
    logic [2:0]   o_dbg_state;
    logic [2:0]   o_dbg_beat_cnt;
    logic         o_dbg_rr_last;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    cache_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rd_req       (i_rd_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .d_rd_req       (d_rd_req),
        .d_wr_req       (d_wr_req),
        .d_addr         (d_addr),
        .d_wr_data      (d_wr_data),
        .d_gnt          (d_gnt),
        .line_rdata     (line_rdata),
        .m_avalid       (m_avalid),
        .m_aready       (m_aready),
        .m_we           (m_we),
        .m_addr         (m_addr),
        .m_wvalid       (m_wvalid),
        .m_wdata        (m_wdata),
        .m_wready       (m_wready),
        .m_bvalid       (m_bvalid),
        .m_rvalid       (m_rvalid),
        .m_rdata        (m_rdata),
        .o_dbg_state    (o_dbg_state),
        .o_dbg_beat_cnt (o_dbg_beat_cnt),
        .o_dbg_rr_last  (o_dbg_rr_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic apply_reset();
        rst_n     = 1'b0;
        i_rd_req  = 1'b0;
        d_rd_req  = 1'b0;
        d_wr_req  = 1'b0;
        m_bvalid  = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Waits from IDLE for the address phase, then plays a full write burst
    // on a zero-wait bus; returns in the DONE cycle.
    task automatic write_burst(input logic [31:0] exp_addr, input logic [31:0] base);
        int n;
        n = 0;
        while (o_dbg_state != ST_ADDR && n < 8) begin
            step();
            n++;
        end
        chk("wr idle cycles", n, 1);
        chk("wr m_avalid", m_avalid, 1'b1);
        chk("wr m_we", m_we, 1'b1);
        chk("wr m_addr", m_addr, exp_addr);
        for (int k = 0; k < 8; k++) exp_q.push_back(base + 32'(k));
        step();
        for (int k = 0; k < 8; k++) begin
            chk("wr m_wvalid", m_wvalid, 1'b1);
            chk("wr m_wdata", m_wdata, exp_q.pop_front());
            step();
        end
        chk("wr in WRESP", o_dbg_state, ST_WRESP);
        chk("wr wvalid low", m_wvalid, 1'b0);
        step();
        chk("wr wait bvalid", o_dbg_state, ST_WRESP);
        chk("wr no early gnt", d_gnt, 1'b0);
        m_bvalid = 1'b1;
        step();
        m_bvalid = 1'b0;
        chk("wr d_gnt", d_gnt, 1'b1);
        chk("wr i_gnt", i_gnt, 1'b0);
    endtask

    // Same for a read burst; rv_gap idle cycles precede each read beat.
    task automatic read_burst(input logic exp_d, input logic [31:0] exp_addr,
                              input logic [31:0] base, input int rv_gap);
        int n;
        n = 0;
        while (o_dbg_state != ST_ADDR && n < 8) begin
            step();
            n++;
        end
        chk("rd idle cycles", n, 1);
        chk("rd m_avalid", m_avalid, 1'b1);
        chk("rd m_we", m_we, 1'b0);
        chk("rd m_addr", m_addr, exp_addr);
        step();
        for (int k = 0; k < 8; k++) begin
            repeat (rv_gap) begin
                m_rvalid = 1'b0;
                m_rdata  = 32'hDEAD_BEEF;
                step();
            end
            m_rvalid = 1'b1;
            m_rdata  = base + 32'(k);
            step();
        end
        m_rvalid = 1'b0;
        m_rdata  = '0;
        chk("rd in DONE", o_dbg_state, ST_DONE);
        chk("rd i_gnt", i_gnt, !exp_d);
        chk("rd d_gnt", d_gnt, exp_d);
        chk("rd line", line_rdata, make_line(base));
    endtask

    initial begin
        m_aready  = 1'b1;
        m_wready  = 1'b1;
        i_addr    = '0;
        d_addr    = '0;
        d_wr_data = '0;
        apply_reset();

        // Reset values
        chk("rst state", o_dbg_state, ST_IDLE);
        chk("rst beat_cnt", o_dbg_beat_cnt, 3'd0);
        chk("rst rr_last", o_dbg_rr_last, OWN_I);
        chk("rst m_avalid", m_avalid, 1'b0);
        chk("rst m_wvalid", m_wvalid, 1'b0);
        chk("rst m_addr", m_addr, 32'h0);
        chk("rst gnts", {i_gnt, d_gnt}, 2'b00);
        chk("rst line", line_rdata, 256'h0);

        // 1: dcache writeback on a zero-wait bus
        d_wr_req  = 1'b1;
        d_addr    = 32'h8000_1234;
        d_wr_data = make_line(32'h100);
        write_burst(32'h8000_1220, 32'h100);
        d_wr_req = 1'b0;
        step();
        chk("t1 gnt one cycle", d_gnt, 1'b0);
        chk("t1 back to idle", o_dbg_state, ST_IDLE);

        // 2: icache refill with read beats every other cycle
        i_rd_req = 1'b1;
        i_addr   = 32'h1FC0_0040;
        read_burst(1'b0, 32'h1FC0_0040, 32'hA0, 1);
        i_rd_req = 1'b0;
        step();
        chk("t2 gnt one cycle", i_gnt, 1'b0);
        chk("t2 line held 1", line_rdata, make_line(32'hA0));
        step();
        chk("t2 line held 2", line_rdata, make_line(32'hA0));

        // 5: dcache refill abandoned after three beats
        d_rd_req = 1'b1;
        d_addr   = 32'h0000_4010;
        step();
        chk("t5 addr phase", o_dbg_state, ST_ADDR);
        chk("t5 m_addr", m_addr, 32'h0000_4000);
        chk("t5 line held to accept", line_rdata, make_line(32'hA0));
        step();
        for (int k = 0; k < 8; k++) begin
            if (k == 3) d_rd_req = 1'b0;
            m_rvalid = 1'b1;
            m_rdata  = 32'hC0 + 32'(k);
            step();
        end
        m_rvalid = 1'b0;
        chk("t5 in DONE", o_dbg_state, ST_DONE);
        chk("t5 no gnt", {i_gnt, d_gnt}, 2'b00);
        step();
        chk("t5 idle", o_dbg_state, ST_IDLE);
        chk("t5 line", line_rdata, make_line(32'hC0));

        // 3: simultaneous requests after reset alternate D,I,D,I
        apply_reset();
        i_rd_req = 1'b1;
        i_addr   = 32'h0000_1000;
        d_rd_req = 1'b1;
        d_addr   = 32'h0000_2000;
        read_burst(1'b1, 32'h0000_2000, 32'hD0, 0);
        step();
        read_burst(1'b0, 32'h0000_1000, 32'h10, 0);
        step();
        read_burst(1'b1, 32'h0000_2000, 32'hD8, 0);
        step();
        read_burst(1'b0, 32'h0000_1000, 32'h18, 0);
        i_rd_req = 1'b0;
        d_rd_req = 1'b0;
        step();

        // 4: writeback, then dcache refill raised in the gnt cycle while icache waits
        d_wr_req  = 1'b1;
        d_addr    = 32'h0000_7000;
        d_wr_data = make_line(32'h300);
        i_rd_req  = 1'b1;
        i_addr    = 32'h0000_8000;
        write_burst(32'h0000_7000, 32'h300);
        d_wr_req = 1'b0;
        d_rd_req = 1'b1;
        d_addr   = 32'h0000_3000;
        step();
        read_burst(1'b0, 32'h0000_8000, 32'h40, 0);
        i_rd_req = 1'b0;
        step();
        read_burst(1'b1, 32'h0000_3000, 32'h50, 0);
        d_rd_req = 1'b0;
        step();
        for (int k = 0; k < 3; k++) begin
            chk("t4 no extra gnt", {i_gnt, d_gnt}, 2'b00);
            chk("t4 stays idle", o_dbg_state, ST_IDLE);
            step();
        end

        // 6: reset asserted during write beat 4
        d_wr_req  = 1'b1;
        d_addr    = 32'h0000_5000;
        d_wr_data = make_line(32'h600);
        step();
        step();
        repeat (4) step();
        chk("t6 at beat 4", m_wdata, 32'h604);
        rst_n = 1'b0;
        #1;
        chk("t6 rst state", o_dbg_state, ST_IDLE);
        chk("t6 rst valids", {m_avalid, m_wvalid, m_we}, 3'b000);
        chk("t6 rst m_wdata", m_wdata, 32'h0);
        chk("t6 rst m_addr", m_addr, 32'h0);
        chk("t6 rst line", line_rdata, 256'h0);
        d_wr_req = 1'b0;
        step();
        step();
        rst_n    = 1'b1;
        i_rd_req = 1'b1;
        i_addr   = 32'h0000_6004;
        read_burst(1'b0, 32'h0000_6000, 32'hE0, 0);
        i_rd_req = 1'b0;
        step();
        chk("t6 final idle", o_dbg_state, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
